mult_job_sequencer: RTL and testbench
=====================================

Name: mult_job_sequencer

Overview:
Job front-end for the shift-add multiplier. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Launches one multiplication at a time with a single-cycle start pulse, captures the product when the multiplier reports done, and returns it over a valid/ready result stream with a job tag. Sits directly upstream and downstream of the shift-add multiplier, whose ports it drives and consumes.

Parameters:
WIDTH, 16, operand width; must match the multiplier's TOP_WIDTH.
DEPTH, 4, operand FIFO entries; power of 2, >= 2.
TAG_W, 4, job tag width.
TIMEOUT_CYCLES, 64, watchdog limit; used only when MJS_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair offered.
in_ready  out  1  FIFO can accept; equals !full.
in_a  in  WIDTH  multiplier operand.
in_b  in  WIDTH  multiplicand operand.
mul_start  out  1  one-cycle start pulse to the multiplier.
mul_multiplier  out  WIDTH  registered operand A to the multiplier.
mul_multiplicand  out  WIDTH  registered operand B to the multiplier.
mul_product  in  2*WIDTH+1  multiplier product.
mul_done  in  1  multiplier done.
res_valid  out  1  result held.
res_ready  in  1  consumer accepts the result.
res_product  out  2*WIDTH+1  captured product.
res_tag  out  TAG_W  tag of the job the result belongs to.
res_err  out  1  result aborted by timeout; 0 when the macro is absent.
busy  out  1  state != IDLE or FIFO not empty.
fifo_count  out  clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values (rst high at an edge):
  - FIFO emptied; fifo_count=0.
  - State=IDLE, tag counter=0.
  - mul_start=0, mul_multiplier=0, mul_multiplicand=0.
  - res_valid=0, res_product=0, res_tag=0, res_err=0, busy=0.
  - Reset mid-job abandons the job. No result is produced for it.
- FIFO push: occurs when in_valid && in_ready.
  - in_ready=0 when full, even if a pop occurs in the same cycle (no pass-through).
  - No bypass. A push into an empty FIFO is launchable on the following cycle.
- IDLE:
  - If FIFO is non-empty and res_valid==0, go to LAUNCH.
  - The head entry is popped and copied into mul_multiplier/mul_multiplicand in the same edge.
- LAUNCH (1 cycle):
  - mul_start=1.
  - Operands stay stable until the next job's launch.
  - Clear the armed flag; go to WAIT.
- WAIT:
  - armed sets on the first cycle mul_done is observed low. This masks a done level left over from the previous job.
  - On mul_done=1 with armed=1:
    - res_product<=mul_product, res_tag<=tag counter, res_err<=0, res_valid<=1.
    - Tag counter increments, wrapping modulo 2^TAG_W.
    - Go to IDLE.
  - mul_done is ignored in IDLE and LAUNCH.
- Result hold:
  - res_valid stays high and res_* stay stable until res_valid && res_ready.
  - res_valid clears on that edge.
  - No new launch occurs while res_valid=1, so at most one job is in flight and one result is held.
- Latency (FIFO empty, res_ready=1):
  - Push at edge N.
  - LAUNCH during cycle N+1, mul_start high.
  - WAIT from N+2.
  - res_valid rises on the edge after the cycle where armed done is seen.
- Pipelining: a new job may be pushed during any state. Pushes do not affect the job in flight.

Optional Feature:
MJS_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without an armed done, set res_valid=1, res_err=1, res_product=0, and res_tag=the current tag.
  - The tag increments and the state returns to IDLE.
  - A late mul_done is then ignored under the normal armed rule.
- Undefined: no counter; WAIT is unbounded; res_err is tied to 0.

Test Plan:
1. Single job, WIDTH=16: push A=16'h96E3, B=16'h36F2 -> mul_start pulses exactly 1 cycle; res_valid with res_product=543327382 and res_tag=0; busy returns to 0.
2. Boundary operands: push 0×16'hFFFF, then 16'hFFFF×16'hFFFF -> results 0 (tag 0), then 33'h0FFFE0001 (tag 1), delivered in order.
3. FIFO full, DEPTH=4, res_ready=0: push 6 pairs -> 1 launched, 4 buffered, in_ready low on the 6th, fifo_count=4; raise res_ready -> all 6 results delivered in order with tags 0..5.
4. Backpressure: hold res_ready=0 after the first result -> mul_start stays 0 and res_* stay stable; release -> the next launch occurs within 2 cycles.
5. Reset mid-WAIT: assert rst for 1 cycle during the 2nd job -> all outputs at reset values; the next pushed job gets tag 0 and a correct product.
6. MJS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, stub multiplier holds mul_done=0 -> res_valid with res_err=1 and res_product=0 eight cycles into WAIT; a subsequent job runs normally with res_err=0.

Source files
------------

// File: rtl/mult_job_sequencer.sv
// Job front-end for the shift-add multiplier: operand FIFO, one-at-a-time launch, tagged result hold.
// Optional watchdog on the multiplier wait is enabled by defining MJS_TIMEOUT_EN.
module mult_job_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_multiplier,
  output logic [WIDTH-1:0]         mul_multiplicand,
  input  logic [2*WIDTH:0]         mul_product,
  input  logic                     mul_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH:0]         res_product,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fifo_a_q [DEPTH];
  logic [WIDTH-1:0] fifo_b_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q;
  logic             armed_q;
  logic [TAG_W-1:0] tag_q;
  logic             res_valid_q, res_err_q;
  logic [PW-1:0]    res_product_q;
  logic [TAG_W-1:0] res_tag_q;

  logic push, pop, done_ok, finish, timeout;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;

`ifdef MJS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;

  // tcnt_q counts completed WAIT cycles; fires on the TIMEOUT_CYCLES-th one.
  assign timeout = (state_q == StWait) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state_q == StLaunch) begin
      tcnt_q <= '0;
    end else if (state_q == StWait) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_ok = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && !res_valid_q) begin
          pop     = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        done_ok = mul_done && armed_q;
        finish  = done_ok || timeout;
        if (finish) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_a;
      fifo_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      armed_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      if (pop) begin
        mul_a_q <= fifo_a_q[rd_ptr_q];
        mul_b_q <= fifo_b_q[rd_ptr_q];
      end
      // armed masks a done level still high from the previous job.
      if (state_q == StLaunch) begin
        armed_q <= 1'b0;
      end else if ((state_q == StWait) && !mul_done) begin
        armed_q <= 1'b1;
      end
      if (finish) begin
        tag_q <= tag_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_tag_q     <= '0;
      res_err_q     <= 1'b0;
    end else if (finish) begin
      res_valid_q   <= 1'b1;
      res_product_q <= done_ok ? mul_product : '0;
      res_tag_q     <= tag_q;
      res_err_q     <= !done_ok;
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign mul_start        = (state_q == StLaunch);
  assign mul_multiplier   = mul_a_q;
  assign mul_multiplicand = mul_b_q;
  assign res_valid        = res_valid_q;
  assign res_product      = res_product_q;
  assign res_tag          = res_tag_q;
  assign res_err          = res_err_q;
  assign busy             = (state_q != StIdle) || (count_q != '0);
  assign fifo_count       = count_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: stub multiplier, queue-based job model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult_job_sequencer;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TW = 4;
  localparam int TO = 8;
  localparam int PW = 2 * W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0, in_ready, res_ready = 1'b1;
  logic [W-1:0]      in_a = '0, in_b = '0;
  logic              mul_start, mul_done, res_valid, res_err, busy;
  logic [W-1:0]      mul_multiplier, mul_multiplicand;
  logic [PW-1:0]     mul_product, res_product;
  logic [TW-1:0]     res_tag;
  logic [$clog2(D):0] fifo_count;

  mult_job_sequencer #(
    .WIDTH(W), .DEPTH(D), .TAG_W(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_product(mul_product), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_tag(res_tag), .res_err(res_err), .busy(busy), .fifo_count(fifo_count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub multiplier: done stays high after completion until the next job drops it.
  logic          m_done, fresh;
  logic [PW-1:0] m_prod;
  int            scnt;
  bit            hang = 0;
  assign mul_done    = m_done;
  assign mul_product = m_prod;

  always @(posedge clk) begin
    if (rst) begin
      m_done <= 1'b0; fresh <= 1'b0; m_prod <= '0; scnt <= 0;
    end else if (mul_start) begin
      scnt  <= $urandom_range(2, 7);
      fresh <= 1'b0;
      m_prod <= PW'($urandom);
    end else if (scnt > 1) begin
      scnt   <= scnt - 1;
      m_done <= 1'b0;
    end else if (scnt == 1) begin
      scnt <= 0;
      if (!hang) begin
        m_done <= 1'b1;
        fresh  <= 1'b1;
        m_prod <= PW'(mul_multiplier) * PW'(mul_multiplicand);
      end
    end
  end

  // Job-level model: queue of pending operand pairs, one job in flight, one result held.
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  op_t           opq[$];
  int            occ = 0, wait_k = 0;
  bit            inflight = 0, held = 0, lcyc = 0, e_err = 0;
  logic [TW-1:0] tag = '0, e_tag = '0;
  logic [PW-1:0] e_prod = '0;
  logic [W-1:0]  cur_a = '0, cur_b = '0;
  logic          mp_push, mp_launch, mp_to, mp_fin;

  always_comb begin
    mp_push   = in_valid && (occ < D);
    mp_launch = !inflight && !held && (occ > 0);
    mp_to     = 1'b0;
`ifdef MJS_TIMEOUT_EN
    mp_to     = inflight && !lcyc && (wait_k == TO) && !fresh;
`endif
    mp_fin    = inflight && !lcyc && (fresh || mp_to);
  end

  always @(posedge clk) begin
    if (rst) begin
      opq.delete();
      occ <= 0; wait_k <= 0; inflight <= 0; held <= 0; lcyc <= 0; e_err <= 0;
      tag <= '0; e_tag <= '0; e_prod <= '0; cur_a <= '0; cur_b <= '0;
    end else begin
      if (mp_launch) begin
        cur_a    <= opq[0].a;
        cur_b    <= opq[0].b;
        void'(opq.pop_front());
        inflight <= 1;
        wait_k   <= 0;
      end
      if (mp_push) opq.push_back(op_t'({in_a, in_b}));
      occ  <= occ + (mp_push ? 1 : 0) - (mp_launch ? 1 : 0);
      lcyc <= mp_launch;
      if (inflight) wait_k <= lcyc ? 1 : wait_k + 1;
      if (mp_fin) begin
        held     <= 1;
        inflight <= 0;
        e_prod   <= mp_to ? '0 : PW'(cur_a) * PW'(cur_b);
        e_tag    <= tag;
        e_err    <= mp_to;
        tag      <= tag + 1'b1;
      end
      if (held && res_ready) held <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, occ < D);
      chk("fifo_count", fifo_count, occ);
      chk("busy", busy, inflight || (occ > 0));
      chk("mul_start", mul_start, lcyc);
      chk("mul_multiplier", mul_multiplier, cur_a);
      chk("mul_multiplicand", mul_multiplicand, cur_b);
      chk("res_valid", res_valid, held);
      chk("res_product", res_product, e_prod);
      chk("res_tag", res_tag, e_tag);
      chk("res_err", res_err, e_err);
    end
  end

  // Accepted-result log and launch counter for the directed literal checks.
  logic [PW-1:0] got_prod[$];
  logic [TW-1:0] got_tag[$];
  bit            got_err[$];
  int            n_start = 0;

  always @(negedge clk) begin
    if (started && !rst) begin
      if (mul_start) n_start++;
      if (res_valid && res_ready) begin
        got_prod.push_back(res_product);
        got_tag.push_back(res_tag);
        got_err.push_back(res_err);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got_prod.delete(); got_tag.delete(); got_err.delete();
    n_start = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_results(input int k, input int budget);
    int n = 0;
    while (got_prod.size() < k && n < budget) begin
      tick(1);
      n++;
    end
    if (got_prod.size() < k) chk("result_timeout", got_prod.size(), k);
  endtask

  task automatic wait_for(input bit use_start, input int budget, output int n);
    n = 0;
    while (!(use_start ? mul_start : res_valid) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) chk("wait_timeout", 0, 1);
  endtask

  logic [W-1:0] t3a[6], t3b[6];

  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(2);
    started = 1;
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    clear_log();

    // Single job.
    push_job(16'h96E3, 16'h36F2);
    wait_results(1, 100);
    tick(2);
    if (got_prod.size() >= 1) begin
      chk("t1_product", got_prod[0], 543327382);
      chk("t1_tag", got_tag[0], 0);
      chk("t1_err", got_err[0], 0);
    end
    chk("t1_start_pulses", n_start, 1);
    chk("t1_busy_idle", busy, 0);

    // Boundary operands.
    do_reset();
    push_job(16'h0000, 16'hFFFF);
    push_job(16'hFFFF, 16'hFFFF);
    wait_results(2, 200);
    if (got_prod.size() >= 2) begin
      chk("t2_prod0", got_prod[0], 0);
      chk("t2_tag0", got_tag[0], 0);
      chk("t2_prod1", got_prod[1], 33'h0FFFE0001);
      chk("t2_tag1", got_tag[1], 1);
    end

    // FIFO full under result backpressure.
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t3a[i] = W'($urandom);
      t3b[i] = W'($urandom);
    end
    for (int i = 0; i < 5; i++) push_job(t3a[i], t3b[i]);
    wait_for(0, 100, n);
    in_valid = 1'b1; in_a = t3a[5]; in_b = t3b[5];
    @(negedge clk);
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_fifo_count", fifo_count, 4);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    push_job(t3a[5], t3b[5]);
    wait_results(6, 500);
    for (int i = 0; i < 6; i++) begin
      if (i < got_prod.size()) begin
        chk("t3_tag", got_tag[i], i);
        chk("t3_prod", got_prod[i], PW'(t3a[i]) * PW'(t3b[i]));
      end
    end

    // Backpressure holds the result and blocks the next launch.
    do_reset();
    res_ready = 1'b0;
    push_job(16'h96E3, 16'h36F2);
    push_job(16'h0003, 16'h0005);
    wait_for(0, 100, n);
    n_start = 0;
    tick(10);
    chk("t4_no_launch", n_start, 0);
    chk("t4_hold_prod", res_product, 543327382);
    chk("t4_hold_tag", res_tag, 0);
    res_ready = 1'b1;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk);
      if (mul_start) n = k;
    end
    chk("t4_relaunch_cycle", n, 3);
    @(posedge clk);
    #1;
    wait_results(2, 100);

    // Reset while the second job is in WAIT.
    do_reset();
    push_job(16'h1111, 16'h2222);
    push_job(16'h3333, 16'h4444);
    wait_results(1, 100);
    wait_for(1, 100, n);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_res_valid", res_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_fifo_count", fifo_count, 0);
    chk("t5_mul_a", mul_multiplier, 0);
    chk("t5_res_tag", res_tag, 0);
    clear_log();
    tick(10);
    chk("t5_no_stale_result", got_prod.size(), 0);
    push_job(16'h1234, 16'h5678);
    wait_results(1, 100);
    if (got_prod.size() >= 1) begin
      chk("t5_tag", got_tag[0], 0);
      chk("t5_prod", got_prod[0], 33'h00626_0060);
    end

`ifdef MJS_TIMEOUT_EN
    // Watchdog with a multiplier that never finishes.
    do_reset();
    hang = 1;
    push_job(16'h00AA, 16'h0055);
    wait_for(1, 50, n);
    wait_for(0, 50, n);
    chk("t6_timeout_cycles", n, TO + 1);
    chk("t6_err", res_err, 1);
    chk("t6_prod", res_product, 0);
    chk("t6_tag", res_tag, 0);
    tick(1);
    hang = 0;
    clear_log();
    push_job(16'h0010, 16'h0020);
    wait_results(1, 100);
    if (got_prod.size() >= 1) begin
      chk("t6_next_err", got_err[0], 0);
      chk("t6_next_tag", got_tag[0], 1);
      chk("t6_next_prod", got_prod[0], 33'h200);
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
      res_ready = (i % 400 < 60) ? 1'b0 : ($urandom_range(0, 2) != 0);
      tick(1);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick(200);
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
